npu_stream_loader: RTL
======================

# npu_stream_loader

Parametrised host-to-NPU memory loader that replaces the fixed-size image/conv/dense write sequencer. Accepts a valid/ready stream of DATA_W-bit host words and distributes them, in a fixed segment order, into the LANES-wide image banks and the byte-wide conv-weight, dense-weight and dense-bias RAMs. Segment lengths are parameters, and back-pressure is supported. Sits between the Avalon register front end and the NPU on-chip RAMs.

## Interface
- LANES, 4, image byte lanes per word; one image bank per lane
- DATA_W, 32, host word width; must equal 8*LANES
- IMG_WORDS, 225, image words (one write to all banks per word)
- CONV_BYTES, 18816, conv weight bytes
- DENSE_BYTES, 16746, dense weight bytes
- DENSEB_BYTES, 10, dense bias bytes
- IMG_AW, 10, image bank address width
- WT_AW, 15, weight/bias RAM address width
- Segment lengths must be at least 1 and fit their address width; otherwise elaboration fails.

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load
- in_valid  in  1  host word valid
- in_data  in  DATA_W  host word
- in_ready  out  1  loader accepts a word this cycle
- img_wren  out  LANES  per-bank write enable
- img_data  out  DATA_W  lane k is in_data[8k+7:8k]
- img_addr  out  IMG_AW  image bank address
- conv_wren, dense_wren, denseb_wren  out  1 each  weight RAM write enables
- wt_data  out  8  weight/bias byte, taken from in_data[7:0]
- conv_addr, dense_addr, denseb_addr  out  WT_AW each  weight RAM addresses
- busy  out  1  high in IMG/CONV/DENSE/DENSEB
- done  out  1  sticky completion flag

## Operation
- FSM states: IDLE, IMG, CONV, DENSE, DENSEB, DONE.
- IDLE or DONE with start=1: go to IMG, clear the segment beat counter, clear done. start is ignored while busy.
- A beat is accepted when in_valid && in_ready. in_ready = busy, combinational from state only.
- Each accepted beat writes exactly one RAM word. The address equals the beat index within the current segment, starting at 0.
- IMG: all LANES bits of img_wren are asserted together, writing the whole word.
- CONV, DENSE, DENSEB: one byte per beat from in_data[7:0]; in_data upper bits are ignored.
- Segment transitions happen on the edge that accepts the last beat of a segment: IMG→CONV after IMG_WORDS beats, CONV→DENSE after CONV_BYTES, DENSE→DENSEB after DENSE_BYTES, DENSEB→DONE after DENSEB_BYTES. The beat counter resets to 0 on each transition.
- Beat counter width: max(IMG_AW, WT_AW) bits. It never wraps, because the transition fires at length-1.
- DONE: done=1, in_ready=0. It stays in DONE until start or reset.
- Idle cycles (in_valid=0) inside a segment stall the loader without side effects. No write strobes are issued.

## Timing
- All write outputs (wren, data, addr) are registered. A beat accepted at edge N drives its write during cycle N..N+1 (one-cycle latency), and the strobe lasts exactly one cycle.
- Back-to-back beats produce strobes on consecutive cycles with consecutive addresses.
- Only one wren group is ever high in a given cycle.
- start at edge T: in_ready is high from T+1.
- Last DENSEB beat accepted at edge N: the denseb write occurs in cycle N..N+1, and done=1 and busy=0 from N+1.
- Reset values: every wren=0, every address=0, img_data=0, wt_data=0, in_ready=0, busy=0, done=0, state=IDLE.
- Reset mid-load: return to IDLE the next edge, with no further strobes. A write registered on that same edge is squashed, so there are no partial trailing writes. A fresh start reloads from address 0.
- start and reset asserted together: reset wins.

## Test plan
Benches use LANES=4, IMG_WORDS=3, CONV_BYTES=2, DENSE_BYTES=2, DENSEB_BYTES=1.
- **Full load, in_valid held high.** Stimulus: start, then 8 words 0x11223344, 0x55667788, … Required response:
  - img_wren=4'hF at addresses 0,1,2.
  - conv_wren at addresses 0,1 with wt_data equal to the low bytes.
  - dense at 0,1, then denseb at 0.
  - done=1 exactly one cycle after the 8th accept, with exactly 8 strobes in total.
- **Back-pressure.** Stimulus: in_valid toggles 1,0,0,1,… Required response: strobes appear only one cycle after accepts, addresses stay gapless, and the final contents match the first test.
- **start while busy.** Stimulus: pulse start after the 2nd image word. Required response: no restart; img_addr continues at 2.
- **Reset after the first conv byte.** Required response: outputs return to reset values the next cycle and no conv_wren at address 1 appears. A new start writes the image at address 0 again.
- **Re-start from DONE.** Required response: done clears the cycle after start, and the second load repeats the identical address sequence.
- **in_valid=1 while IDLE or DONE.** Required response: in_ready=0 and no writes.

Source files
------------

// File: rtl/npu_stream_loader.sv
// Host-to-NPU memory loader: distributes a valid/ready word stream into the image banks
// and the conv-weight, dense-weight and dense-bias RAMs, in a fixed segment order.
module npu_stream_loader #(
    parameter int LANES        = 4,
    parameter int DATA_W       = 32,
    parameter int IMG_WORDS    = 225,
    parameter int CONV_BYTES   = 18816,
    parameter int DENSE_BYTES  = 16746,
    parameter int DENSEB_BYTES = 10,
    parameter int IMG_AW       = 10,
    parameter int WT_AW        = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [LANES-1:0]  img_wren,
    output logic [DATA_W-1:0] img_data,
    output logic [IMG_AW-1:0] img_addr,
    output logic              conv_wren,
    output logic              dense_wren,
    output logic              denseb_wren,
    output logic [7:0]        wt_data,
    output logic [WT_AW-1:0]  conv_addr,
    output logic [WT_AW-1:0]  dense_addr,
    output logic [WT_AW-1:0]  denseb_addr,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (IMG_AW > WT_AW) ? IMG_AW : WT_AW;

    if (DATA_W != 8 * LANES) begin : g_bad_width
        $error("npu_stream_loader: DATA_W must equal 8*LANES");
    end
    if (IMG_WORDS < 1 || 64'(IMG_WORDS) > (64'd1 << IMG_AW)) begin : g_bad_img
        $error("npu_stream_loader: IMG_WORDS out of range for IMG_AW");
    end
    if (CONV_BYTES < 1 || 64'(CONV_BYTES) > (64'd1 << WT_AW)) begin : g_bad_conv
        $error("npu_stream_loader: CONV_BYTES out of range for WT_AW");
    end
    if (DENSE_BYTES < 1 || 64'(DENSE_BYTES) > (64'd1 << WT_AW)) begin : g_bad_dense
        $error("npu_stream_loader: DENSE_BYTES out of range for WT_AW");
    end
    if (DENSEB_BYTES < 1 || 64'(DENSEB_BYTES) > (64'd1 << WT_AW)) begin : g_bad_denseb
        $error("npu_stream_loader: DENSEB_BYTES out of range for WT_AW");
    end

    localparam logic [CNT_W-1:0] IMG_LAST    = CNT_W'(IMG_WORDS - 1);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_BYTES - 1);
    localparam logic [CNT_W-1:0] DENSE_LAST  = CNT_W'(DENSE_BYTES - 1);
    localparam logic [CNT_W-1:0] DENSEB_LAST = CNT_W'(DENSEB_BYTES - 1);

    typedef enum logic [2:0] {IDLE, IMG, CONV, DENSE, DENSEB, DONE} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                img_wr_reg;
    logic [DATA_W-1:0]   img_data_reg;
    logic [IMG_AW-1:0]   img_addr_reg;
    logic                conv_wr_reg;
    logic                dense_wr_reg;
    logic                denseb_wr_reg;
    logic [7:0]          wt_data_reg;
    logic [WT_AW-1:0]    conv_addr_reg;
    logic [WT_AW-1:0]    dense_addr_reg;
    logic [WT_AW-1:0]    denseb_addr_reg;
    logic                seg_last;

    always_comb begin
        seg_last = 1'b0;
        case (state_reg)
            IMG:     seg_last = (cnt_reg == IMG_LAST);
            CONV:    seg_last = (cnt_reg == CONV_LAST);
            DENSE:   seg_last = (cnt_reg == DENSE_LAST);
            DENSEB:  seg_last = (cnt_reg == DENSEB_LAST);
            default: seg_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            img_wr_reg      <= 1'b0;
            img_data_reg    <= '0;
            img_addr_reg    <= '0;
            conv_wr_reg     <= 1'b0;
            dense_wr_reg    <= 1'b0;
            denseb_wr_reg   <= 1'b0;
            wt_data_reg     <= '0;
            conv_addr_reg   <= '0;
            dense_addr_reg  <= '0;
            denseb_addr_reg <= '0;
        end else begin
            // Strobes are single-cycle; data and addresses hold their last value.
            img_wr_reg    <= 1'b0;
            conv_wr_reg   <= 1'b0;
            dense_wr_reg  <= 1'b0;
            denseb_wr_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= IMG;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    if (in_valid) begin
                        cnt_reg <= seg_last ? '0 : cnt_reg + 1'b1;
                        case (state_reg)
                            IMG: begin
                                img_wr_reg   <= 1'b1;
                                img_data_reg <= in_data;
                                img_addr_reg <= cnt_reg[IMG_AW-1:0];
                                if (seg_last) state_reg <= CONV;
                            end
                            CONV: begin
                                conv_wr_reg   <= 1'b1;
                                wt_data_reg   <= in_data[7:0];
                                conv_addr_reg <= cnt_reg[WT_AW-1:0];
                                if (seg_last) state_reg <= DENSE;
                            end
                            DENSE: begin
                                dense_wr_reg   <= 1'b1;
                                wt_data_reg    <= in_data[7:0];
                                dense_addr_reg <= cnt_reg[WT_AW-1:0];
                                if (seg_last) state_reg <= DENSEB;
                            end
                            default: begin
                                denseb_wr_reg   <= 1'b1;
                                wt_data_reg     <= in_data[7:0];
                                denseb_addr_reg <= cnt_reg[WT_AW-1:0];
                                if (seg_last) state_reg <= DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign img_wren[gi]         = img_wr_reg;
        assign img_data[8*gi +: 8]  = img_data_reg[8*gi +: 8];
    end

    assign busy        = (state_reg == IMG) || (state_reg == CONV) ||
                         (state_reg == DENSE) || (state_reg == DENSEB);
    assign in_ready    = busy;
    assign done        = (state_reg == DONE);
    assign img_addr    = img_addr_reg;
    assign conv_wren   = conv_wr_reg;
    assign dense_wren  = dense_wr_reg;
    assign denseb_wren = denseb_wr_reg;
    assign wt_data     = wt_data_reg;
    assign conv_addr   = conv_addr_reg;
    assign dense_addr  = dense_addr_reg;
    assign denseb_addr = denseb_addr_reg;
endmodule
